// File: rtl/dfe_stage_monitor_if.sv
// Stage bus and capture read-out port between the DFE chain and its monitor.
// The master drives the per-stage samples, flags and read requests.
// The slave, which is the monitor, returns the popped capture samples.
interface dfe_stage_monitor_if #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_STAGES = 4
);
   logic [NUM_STAGES*DATA_WIDTH-1:0] stage_data;
   logic [NUM_STAGES-1:0]            stage_valid;
   logic [NUM_STAGES-1:0]            stage_ovf;
   logic [NUM_STAGES-1:0]            stage_unf;
   logic                             rd_en;
   logic [DATA_WIDTH-1:0]            rd_data;
   logic                             rd_valid;

   modport master (
      output stage_data, stage_valid, stage_ovf, stage_unf, rd_en,
      input  rd_data, rd_valid
   );

   modport slave (
      input  stage_data, stage_valid, stage_ovf, stage_unf, rd_en,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/dfe_stage_monitor.sv
// Observation and capture block for an N-stage DFE chain.
// It provides a registered monitor mux, per-stage sticky ovf/unf flags and a saturating sample
// counter on the selected stage. A triggered capture buffer is drained by software once the
// capture has completed.
module dfe_stage_monitor #(
   parameter  int DATA_WIDTH = 16,
   parameter  int NUM_STAGES = 4,
   parameter  int CAP_DEPTH  = 64,
   parameter  int CNT_WIDTH  = 16,
   localparam int SEL_W      = $clog2(NUM_STAGES + 1),
   localparam int LEN_W      = $clog2(CAP_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   dfe_stage_monitor_if.slave    bus,
   input  logic [SEL_W-1:0]      cfg_sel,
   input  logic                  cap_arm,
   input  logic                  cap_trig_mode,
   input  logic [LEN_W-1:0]      cap_len,
   input  logic                  clr_sticky,
   output logic [DATA_WIDTH-1:0] mon_data,
   output logic                  mon_valid,
   output logic                  mon_ovf,
   output logic                  mon_unf,
   output logic [NUM_STAGES-1:0] sticky_ovf,
   output logic [NUM_STAGES-1:0] sticky_unf,
   output logic [CNT_WIDTH-1:0]  sample_cnt,
   output logic [1:0]            cap_state,
   output logic [LEN_W-1:0]      cap_count,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);
   localparam int PTR_W = $clog2(CAP_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ARMED   = 2'b01,
      ST_CAPTURE = 2'b10,
      ST_DONE    = 2'b11
   } cap_state_t;

   // selected-stage view (combinational, registered below)
   logic [DATA_WIDTH-1:0] sel_data_s;
   logic                  sel_valid_s;
   logic                  sel_ovf_s;
   logic                  sel_unf_s;
   logic [SEL_W-1:0]      sel_prev_r;
   logic                  sel_change_s;

   // monitor and status registers
   logic [DATA_WIDTH-1:0] mon_data_r;
   logic                  mon_valid_r;
   logic                  mon_ovf_r;
   logic                  mon_unf_r;
   logic [NUM_STAGES-1:0] sticky_ovf_r;
   logic [NUM_STAGES-1:0] sticky_unf_r;
   logic [CNT_WIDTH-1:0]  sample_cnt_r;

   // capture control
   cap_state_t            state_r, state_nx;
   logic [LEN_W-1:0]      count_r, count_nx, count_inc_s;
   logic [LEN_W-1:0]      len_r, len_nx, eff_len_s;
   logic                  mode_r, mode_nx;
   logic [PTR_W-1:0]      wr_ptr_r, wr_ptr_nx;
   logic [PTR_W-1:0]      rd_ptr_r, rd_ptr_nx;
   logic                  wr_en_s;
   logic                  rd_fire_s;
   logic [DATA_WIDTH-1:0] rd_data_r;
   logic                  rd_valid_r;

   logic [DATA_WIDTH-1:0] mem_r [CAP_DEPTH];

   assign sel_change_s = (cfg_sel != sel_prev_r);
   assign count_inc_s  = count_r + LEN_W'(1);
   // A length of zero, or one larger than the buffer, means "fill the whole buffer".
   assign eff_len_s    = ((cap_len == LEN_W'(0)) || (cap_len > LEN_W'(CAP_DEPTH)))
                         ? LEN_W'(CAP_DEPTH) : cap_len;

   // Pick the stage addressed by cfg_sel; codes 0 and above NUM_STAGES select nothing.
   always_comb begin
      sel_data_s  = '0;
      sel_valid_s = 1'b0;
      sel_ovf_s   = 1'b0;
      sel_unf_s   = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (cfg_sel == SEL_W'(k + 1)) begin
            sel_data_s  = bus.stage_data[k*DATA_WIDTH +: DATA_WIDTH];
            sel_valid_s = bus.stage_valid[k];
            sel_ovf_s   = bus.stage_ovf[k];
            sel_unf_s   = bus.stage_unf[k];
         end else begin
            sel_valid_s = sel_valid_s;
         end
      end
   end

   // Register the monitor path and remember the selector to detect changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mon_data_r  <= '0;
         mon_valid_r <= 1'b0;
         mon_ovf_r   <= 1'b0;
         mon_unf_r   <= 1'b0;
         sel_prev_r  <= '0;
      end else begin
         mon_data_r  <= sel_data_s;
         mon_valid_r <= sel_valid_s;
         mon_ovf_r   <= sel_ovf_s;
         mon_unf_r   <= sel_unf_s;
         sel_prev_r  <= cfg_sel;
      end
   end

   // Sticky flags: a set arriving with the clear survives it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_ovf_r <= '0;
         sticky_unf_r <= '0;
      end else if (clr_sticky) begin
         sticky_ovf_r <= bus.stage_ovf;
         sticky_unf_r <= bus.stage_unf;
      end else begin
         sticky_ovf_r <= sticky_ovf_r | bus.stage_ovf;
         sticky_unf_r <= sticky_unf_r | bus.stage_unf;
      end
   end

   // Count registered valids on the selected stage; restart whenever the selection moves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_cnt_r <= '0;
      end else if (sel_change_s) begin
         sample_cnt_r <= '0;
      end else if (mon_valid_r && (sample_cnt_r != {CNT_WIDTH{1'b1}})) begin
         sample_cnt_r <= sample_cnt_r + CNT_WIDTH'(1);
      end else begin
         sample_cnt_r <= sample_cnt_r;
      end
   end

   // Capture FSM next-state: arming, triggering, filling, draining and aborting.
   always_comb begin
      state_nx  = state_r;
      count_nx  = count_r;
      len_nx    = len_r;
      mode_nx   = mode_r;
      wr_ptr_nx = wr_ptr_r;
      rd_ptr_nx = rd_ptr_r;
      wr_en_s   = 1'b0;
      rd_fire_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cap_arm) begin
               state_nx  = ST_ARMED;
               count_nx  = '0;
               wr_ptr_nx = '0;
               rd_ptr_nx = '0;
               len_nx    = eff_len_s;
               mode_nx   = cap_trig_mode;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (sel_change_s) begin
               state_nx = ST_IDLE;
               count_nx = '0;
            end else if (!mode_r) begin
               state_nx = ST_CAPTURE;
            end else if (mon_ovf_r || mon_unf_r) begin
               // the triggering sample itself becomes sample 0 when it is valid
               state_nx = ST_CAPTURE;
               wr_en_s  = mon_valid_r;
            end else begin
               state_nx = ST_ARMED;
            end
         end
         ST_CAPTURE: begin
            if (sel_change_s) begin
               state_nx = ST_IDLE;
               count_nx = '0;
            end else begin
               wr_en_s = mon_valid_r;
            end
         end
         ST_DONE: begin
            if (cap_arm) begin
               state_nx  = ST_ARMED;
               count_nx  = '0;
               wr_ptr_nx = '0;
               rd_ptr_nx = '0;
               len_nx    = eff_len_s;
               mode_nx   = cap_trig_mode;
            end else if (bus.rd_en && (count_r != LEN_W'(0))) begin
               rd_fire_s = 1'b1;
               rd_ptr_nx = rd_ptr_r + PTR_W'(1);
               count_nx  = count_r - LEN_W'(1);
               state_nx  = (count_r == LEN_W'(1)) ? ST_IDLE : ST_DONE;
            end else begin
               state_nx = ST_DONE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            count_nx = '0;
         end
      endcase
      // Shared bookkeeping for a buffer write; the final write lands with the move to DONE.
      if (wr_en_s) begin
         wr_ptr_nx = wr_ptr_r + PTR_W'(1);
         count_nx  = count_inc_s;
         state_nx  = (count_inc_s == len_r) ? ST_DONE : ST_CAPTURE;
      end else begin
         wr_ptr_nx = wr_ptr_nx;
      end
   end

   // Capture FSM state, pointers and read-out registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         count_r    <= '0;
         len_r      <= '0;
         mode_r     <= 1'b0;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= '0;
      end else begin
         state_r    <= state_nx;
         count_r    <= count_nx;
         len_r      <= len_nx;
         mode_r     <= mode_nx;
         wr_ptr_r   <= wr_ptr_nx;
         rd_ptr_r   <= rd_ptr_nx;
         rd_valid_r <= rd_fire_s;
         if (rd_fire_s) begin
            rd_data_r <= mem_r[rd_ptr_r];
         end
      end
   end

   // Capture memory write port; contents are not reset, the count marks what is valid.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= mon_data_r;
      end
   end

   assign mon_data     = mon_data_r;
   assign mon_valid    = mon_valid_r;
   assign mon_ovf      = mon_ovf_r;
   assign mon_unf      = mon_unf_r;
   assign sticky_ovf   = sticky_ovf_r;
   assign sticky_unf   = sticky_unf_r;
   assign sample_cnt   = sample_cnt_r;
   assign cap_state    = state_r;
   assign cap_count    = count_r;
   assign rd_data      = rd_data_r;
   assign rd_valid     = rd_valid_r;
   assign bus.rd_data  = rd_data_r;
   assign bus.rd_valid = rd_valid_r;

endmodule

// File: tb/tb_dfe_stage_monitor.sv
// Testbench for dfe_stage_monitor.
// Directed scenarios are followed by a randomized run. All of it is checked every cycle
// against a queue-based reference model of the monitor and capture rules.
module tb_dfe_stage_monitor;
   localparam int DW = 16;
   localparam int NS = 4;
   localparam int CD = 64;
   localparam int CW = 4;
   localparam int SW = 3;
   localparam int LW = 7;

   logic          clk;
   logic          rst;
   logic [NS*DW-1:0] s_data;
   logic [NS-1:0] s_valid, s_ovf, s_unf;
   logic          rd_en;
   logic [SW-1:0] cfg_sel;
   logic          cap_arm, cap_trig_mode, clr_sticky;
   logic [LW-1:0] cap_len;
   logic [DW-1:0] mon_data, rd_data;
   logic          mon_valid, mon_ovf, mon_unf, rd_valid;
   logic [NS-1:0] sticky_ovf, sticky_unf;
   logic [CW-1:0] sample_cnt;
   logic [1:0]    cap_state;
   logic [LW-1:0] cap_count;

   int n_total = 0;
   int n_bad   = 0;

   dfe_stage_monitor_if #(.DATA_WIDTH(DW), .NUM_STAGES(NS)) bus ();
   assign bus.stage_data  = s_data;
   assign bus.stage_valid = s_valid;
   assign bus.stage_ovf   = s_ovf;
   assign bus.stage_unf   = s_unf;
   assign bus.rd_en       = rd_en;

   dfe_stage_monitor #(.DATA_WIDTH(DW), .NUM_STAGES(NS), .CAP_DEPTH(CD), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .cfg_sel(cfg_sel), .cap_arm(cap_arm), .cap_trig_mode(cap_trig_mode),
      .cap_len(cap_len), .clr_sticky(clr_sticky),
      .mon_data(mon_data), .mon_valid(mon_valid), .mon_ovf(mon_ovf), .mon_unf(mon_unf),
      .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .sample_cnt(sample_cnt),
      .cap_state(cap_state), .cap_count(cap_count), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [DW-1:0] m_mon_data;
   bit            m_mon_valid, m_mon_ovf, m_mon_unf;
   logic [NS-1:0] m_sov, m_sun;
   int            m_cnt;
   logic [SW-1:0] m_prev_sel;
   int            m_state;          // 0 idle, 1 armed, 2 capture, 3 done
   logic [DW-1:0] m_q[$];           // captured samples, oldest first
   int            m_len;
   bit            m_mode;
   bit            m_rdv;
   logic [DW-1:0] m_rdd;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_mon_data = '0; m_mon_valid = 0; m_mon_ovf = 0; m_mon_unf = 0;
      m_sov = '0; m_sun = '0; m_cnt = 0; m_prev_sel = '0;
      m_state = 0; m_q.delete(); m_len = 0; m_mode = 0; m_rdv = 0; m_rdd = '0;
   endtask

   task automatic model_arm();
      m_q.delete();
      m_len   = (cap_len == 0 || int'(cap_len) > CD) ? CD : int'(cap_len);
      m_mode  = cap_trig_mode;
      m_state = 1;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      int            sel;
      bit            chg;
      logic [DW-1:0] nd;
      bit            nv, no, nu;
      sel = int'(cfg_sel);
      chg = (cfg_sel != m_prev_sel);
      nd = '0; nv = 0; no = 0; nu = 0;
      if (sel >= 1 && sel <= NS) begin
         nd = s_data[(sel-1)*DW +: DW];
         nv = s_valid[sel-1];
         no = s_ovf[sel-1];
         nu = s_unf[sel-1];
      end
      m_rdv = 0;
      case (m_state)
         0: if (cap_arm) model_arm();
         1: begin
            if (chg) begin m_state = 0; m_q.delete(); end
            else if (!m_mode) m_state = 2;
            else if (m_mon_ovf || m_mon_unf) begin
               if (m_mon_valid) m_q.push_back(m_mon_data);
               m_state = (m_q.size() == m_len) ? 3 : 2;
            end
         end
         2: begin
            if (chg) begin m_state = 0; m_q.delete(); end
            else if (m_mon_valid) begin
               m_q.push_back(m_mon_data);
               if (m_q.size() == m_len) m_state = 3;
            end
         end
         default: begin
            if (cap_arm) model_arm();
            else if (rd_en && m_q.size() > 0) begin
               m_rdd = m_q.pop_front();
               m_rdv = 1;
               if (m_q.size() == 0) m_state = 0;
            end
         end
      endcase
      m_sov = clr_sticky ? s_ovf : (m_sov | s_ovf);
      m_sun = clr_sticky ? s_unf : (m_sun | s_unf);
      if (chg) m_cnt = 0;
      else if (m_mon_valid && m_cnt < (2**CW - 1)) m_cnt++;
      m_mon_data = nd; m_mon_valid = nv; m_mon_ovf = no; m_mon_unf = nu;
      m_prev_sel = cfg_sel;
   endtask

   task automatic compare_all();
      check_eq("mon_data",   32'(mon_data),   32'(m_mon_data));
      check_eq("mon_valid",  32'(mon_valid),  32'(m_mon_valid));
      check_eq("mon_ovf",    32'(mon_ovf),    32'(m_mon_ovf));
      check_eq("mon_unf",    32'(mon_unf),    32'(m_mon_unf));
      check_eq("sticky_ovf", 32'(sticky_ovf), 32'(m_sov));
      check_eq("sticky_unf", 32'(sticky_unf), 32'(m_sun));
      check_eq("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
      check_eq("cap_state",  32'(cap_state),  32'(m_state));
      check_eq("cap_count",  32'(cap_count),  32'(m_q.size()));
      check_eq("rd_valid",   32'(rd_valid),   32'(m_rdv));
      if (m_rdv) check_eq("rd_data", 32'(rd_data), 32'(m_rdd));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_mon"}, {mon_data, 3'(0), mon_valid, mon_ovf, mon_unf}, 32'd0);
      check_eq({tag, "_sticky"}, {24'd0, sticky_ovf, sticky_unf}, 32'd0);
      check_eq({tag, "_cnt"}, 32'(sample_cnt), 32'd0);
      check_eq({tag, "_cap"}, {cap_state, cap_count, rd_valid}, 10'd0);
      check_eq({tag, "_rd_data"}, 32'(rd_data), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] trig_exp [4];
      logic [LW-1:0] len_tab [10];
      trig_exp[0] = 16'h7FFF; trig_exp[1] = 16'd21; trig_exp[2] = 16'd22; trig_exp[3] = 16'd23;
      len_tab[0] = 7'd0;  len_tab[1] = 7'd1;  len_tab[2] = 7'd2;   len_tab[3] = 7'd3;
      len_tab[4] = 7'd5;  len_tab[5] = 7'd8;  len_tab[6] = 7'd64;  len_tab[7] = 7'd65;
      len_tab[8] = 7'd100; len_tab[9] = 7'd127;

      // reset with a live selection on stage 2
      rst = 1'b1;
      s_data = 64'h0000_1234_0000_0000; s_valid = 4'b0100; s_ovf = '0; s_unf = '0;
      rd_en = 1'b0; cfg_sel = 3'd3; cap_arm = 1'b0; cap_trig_mode = 1'b0;
      cap_len = 7'd0; clr_sticky = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // monitor mux
      tick();
      check_eq("mux_sel3_data", 32'(mon_data), 32'h1234);
      check_eq("mux_sel3_valid", 32'(mon_valid), 32'd1);
      cfg_sel = 3'd5;
      tick();
      check_eq("mux_sel5_data", 32'(mon_data), 32'd0);
      check_eq("mux_sel5_valid", 32'(mon_valid), 32'd0);

      // sticky flags, set beats clear
      cfg_sel = 3'd1;
      s_ovf = 4'b0010; tick();
      check_eq("sticky_set", 32'(sticky_ovf), 32'h2);
      s_ovf = 4'b0000; tick();
      check_eq("sticky_hold", 32'(sticky_ovf), 32'h2);
      clr_sticky = 1'b1; s_unf = 4'b0001; tick();
      check_eq("sticky_clr_ovf", 32'(sticky_ovf), 32'h0);
      check_eq("sticky_setwin_unf", 32'(sticky_unf), 32'h1);
      clr_sticky = 1'b0; s_unf = 4'b0000; tick();
      check_eq("sticky_unf_kept", 32'(sticky_unf), 32'h1);

      // saturating counter and clear on selector change
      cfg_sel = 3'd2; s_valid = 4'hF;
      repeat (22) tick();
      check_eq("cnt_saturate", 32'(sample_cnt), 32'd15);
      cfg_sel = 3'd3; tick();
      check_eq("cnt_sel_clear", 32'(sample_cnt), 32'd0);

      // immediate capture of a ramp
      cfg_sel = 3'd1; cap_len = 7'd8; cap_trig_mode = 1'b0; tick();
      cap_arm = 1'b1; s_data[15:0] = 16'd100; tick();
      cap_arm = 1'b0;
      check_eq("imm_armed", 32'(cap_state), 32'd1);
      for (int i = 0; i < 16; i++) begin
         s_data[15:0] = 16'(i);
         tick();
      end
      check_eq("imm_done", 32'(cap_state), 32'd3);
      check_eq("imm_count", 32'(cap_count), 32'd8);
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq("imm_rd_valid", 32'(rd_valid), 32'd1);
         check_eq("imm_rd_data", 32'(rd_data), 32'(i));
      end
      rd_en = 1'b0;
      check_eq("imm_idle", 32'(cap_state), 32'd0);
      tick();
      check_eq("imm_rd_pulse", 32'(rd_valid), 32'd0);

      // triggered capture on an overflow sample
      cap_len = 7'd4; cap_trig_mode = 1'b1;
      cap_arm = 1'b1; s_data[15:0] = 16'd9; tick();
      cap_arm = 1'b0;
      for (int v = 10; v <= 30; v++) begin
         s_data[15:0] = (v == 20) ? 16'h7FFF : 16'(v);
         s_ovf = (v == 20) ? 4'b0001 : 4'b0000;
         tick();
         if (v == 20) begin
            check_eq("trig_no_early_write", 32'(cap_count), 32'd0);
            check_eq("trig_still_armed", 32'(cap_state), 32'd1);
         end
      end
      check_eq("trig_count", 32'(cap_count), 32'd4);
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("trig_rd_data", 32'(rd_data), 32'(trig_exp[i]));
      end
      rd_en = 1'b0;
      check_eq("trig_idle", 32'(cap_state), 32'd0);

      // length clamp: zero, then re-arm in DONE with an oversize length
      cap_len = 7'd0; cap_trig_mode = 1'b0;
      cap_arm = 1'b1; tick(); cap_arm = 1'b0;
      for (int i = 0; i < 80; i++) begin s_data[15:0] = 16'(i + 300); tick(); end
      check_eq("clamp0_done", 32'(cap_state), 32'd3);
      check_eq("clamp0_count", 32'(cap_count), 32'd64);
      rd_en = 1'b1; repeat (61) tick(); rd_en = 1'b0;
      check_eq("clamp0_left", 32'(cap_count), 32'd3);
      cap_len = 7'd100; cap_arm = 1'b1; tick(); cap_arm = 1'b0;
      check_eq("rearm_state", 32'(cap_state), 32'd1);
      check_eq("rearm_count", 32'(cap_count), 32'd0);
      for (int i = 0; i < 80; i++) begin s_data[15:0] = 16'(i + 500); tick(); end
      check_eq("clamp100_count", 32'(cap_count), 32'd64);
      rd_en = 1'b1; repeat (64) tick(); rd_en = 1'b0;
      check_eq("clamp100_idle", 32'(cap_state), 32'd0);

      // abort on selector change mid capture, then rd_en while idle
      cap_len = 7'd8; cap_arm = 1'b1; tick(); cap_arm = 1'b0;
      repeat (4) tick();
      check_eq("abort_pre_state", 32'(cap_state), 32'd2);
      cfg_sel = 3'd2; tick();
      check_eq("abort_state", 32'(cap_state), 32'd0);
      check_eq("abort_count", 32'(cap_count), 32'd0);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      check_eq("idle_rd_ignored", 32'(rd_valid), 32'd0);

      // asynchronous reset in the middle of a capture
      cap_arm = 1'b1; tick(); cap_arm = 1'b0;
      repeat (3) tick();
      #3 rst = 1'b1;
      #1;
      check_all_zero("midcap_reset");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      compare_all();

      // randomized run
      for (int n = 0; n < 4000; n++) begin
         s_data     = {$urandom, $urandom};
         s_valid    = 4'($urandom_range(0, 15));
         s_ovf      = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         s_unf      = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         clr_sticky = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 199) == 0) cfg_sel = 3'($urandom_range(0, 7));
         cap_arm       = ($urandom_range(0, 29) == 0);
         cap_trig_mode = 1'($urandom_range(0, 1));
         cap_len       = ($urandom_range(0, 1) == 0) ? len_tab[$urandom_range(0, 9)]
                                                     : 7'($urandom_range(0, 127));
         rd_en         = ($urandom_range(0, 2) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/dfe_stage_monitor.md
Name: dfe_stage_monitor

Overview:
- Parametrised observation and capture block for an N-stage DFE chain. It replaces the fixed 4-way output, status and valid selection with a registered monitor path for any stage count.
- It adds per-stage sticky overflow/underflow flags, a saturating sample counter and a triggered capture buffer that software drains after the capture completes.
- It sits beside the filter core and is driven by the configuration register block.

Parameters:
- DATA_WIDTH, 16, sample width (signed).
- NUM_STAGES, 4, number of monitored stages.
- CAP_DEPTH, 64, capture buffer depth in samples; power of two, at least 2.
- CNT_WIDTH, 16, sample counter width.
- SEL_W (localparam), $clog2(NUM_STAGES+1), selector width.
- LEN_W (localparam), $clog2(CAP_DEPTH)+1, length and count width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stage_data  in  NUM_STAGES*DATA_WIDTH  flattened stage outputs; stage k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- stage_valid  in  NUM_STAGES  per-stage valid
- stage_ovf  in  NUM_STAGES  per-stage overflow
- stage_unf  in  NUM_STAGES  per-stage underflow
- cfg_sel  in  SEL_W  0 = none, k = stage k-1
- cap_arm  in  1  single-cycle arm pulse
- cap_trig_mode  in  1  0 = start immediately, 1 = start on selected-stage ovf/unf
- cap_len  in  LEN_W  samples to capture
- clr_sticky  in  1  clears sticky flags
- rd_en  in  1  pop one captured sample
- mon_data  out  DATA_WIDTH  registered selected data
- mon_valid  out  1  registered selected valid
- mon_ovf  out  1  registered selected overflow
- mon_unf  out  1  registered selected underflow
- sticky_ovf  out  NUM_STAGES  latched overflow per stage
- sticky_unf  out  NUM_STAGES  latched underflow per stage
- sample_cnt  out  CNT_WIDTH  valid samples seen on selected stage
- cap_state  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE
- cap_count  out  LEN_W  samples currently held in buffer
- rd_data  out  DATA_WIDTH  popped sample
- rd_valid  out  1  rd_data valid

Behaviour:
- Reset (rst high, asynchronous): every output is 0, the FSM is IDLE and the buffer pointers are 0.
- Monitor path: one-cycle registered mux. cfg_sel = 0 or cfg_sel > NUM_STAGES drives mon_data/mon_valid/mon_ovf/mon_unf to 0.
- Sticky flags:
  - sticky_ovf[k] sets on any cycle where stage_ovf[k] = 1; sticky_unf[k] likewise from stage_unf[k]. Flags track every stage independently of cfg_sel.
  - clr_sticky clears all flags. If a set and clr_sticky fall on the same cycle, the set wins.
- Sample counter:
  - sample_cnt increments on each registered mon_valid and saturates at all-ones.
  - Any change of cfg_sel clears it to 0 on the next cycle.
- Effective length: L = CAP_DEPTH when cap_len = 0 or cap_len > CAP_DEPTH; otherwise L = cap_len. L is latched at arm.
- Capture FSM:
  - IDLE: cap_arm moves to ARMED, clears the buffer and cap_count, and latches L and cap_trig_mode.
  - ARMED:
    - Mode 0 moves to CAPTURE on the next cycle.
    - Mode 1 moves to CAPTURE on the first cycle where mon_ovf or mon_unf = 1. That triggering sample is stored as sample 0 if mon_valid = 1.
  - CAPTURE: each mon_valid writes mon_data at wr_ptr and increments cap_count. When cap_count reaches L, move to DONE; the last write and the transition happen on the same edge.
  - DONE:
    - rd_en with cap_count > 0 gives rd_data = oldest sample and rd_valid = 1 on the next cycle, then decrements cap_count.
    - When cap_count reaches 0 after a pop, move to IDLE.
    - rd_en with cap_count = 0 is ignored (rd_valid stays 0).
  - cap_arm in ARMED or CAPTURE is ignored. cap_arm in DONE discards unread data and re-arms (same as from IDLE).
  - A cfg_sel change in ARMED or CAPTURE aborts to IDLE and sets cap_count to 0. In DONE it has no effect.
  - rd_en outside DONE is ignored.
- rd_valid is a single-cycle pulse per accepted pop; back-to-back rd_en gives back-to-back samples.
- Buffer: CAP_DEPTH x DATA_WIDTH memory with one synchronous write and one synchronous read port. Pointers wrap modulo CAP_DEPTH.
- Reset mid-capture: immediate return to IDLE with the buffer contents invalidated.

Test Plan:
- Reset and mux: assert rst, NUM_STAGES = 4, cfg_sel = 3, stage 2 data = 16'h1234 valid -> all outputs 0 during reset. After release, mon_data = 16'h1234 one cycle after input; cfg_sel = 5 -> mon_* = 0.
- Sticky: pulse stage_ovf[1] once, then assert clr_sticky and stage_unf[0] in the same cycle -> sticky_ovf = 4'b0010 until the clear cycle, then 0. sticky_unf = 4'b0001 remains set.
- Immediate capture: cfg_sel = 1, cap_len = 8, mode 0, arm, feed ramp 0..15 with valid every cycle -> DONE with cap_count = 8. Eight rd_en pulses return 0..7 (first-arrival order) with rd_valid, then state IDLE.
- Triggered capture: mode 1, cap_len = 4, stage_ovf asserted with sample 16'h7FFF at ramp value 20 -> buffer holds 7FFF,21,22,23. No write occurs before the trigger.
- Length clamp and counter: cap_len = 0, then cap_len = 100 with CAP_DEPTH = 64 -> each capture stores exactly 64 samples. Run CNT_WIDTH = 4 with 20 valids -> sample_cnt = 15; change cfg_sel -> sample_cnt = 0.
- Abort and re-arm: change cfg_sel mid-CAPTURE -> IDLE, cap_count = 0. Arm in DONE with 3 samples unread -> ARMED, cap_count = 0. rd_en while IDLE -> no rd_valid.
